uart_tx_frame: RTL and testbench

UART transmitter that serializes one parallel byte into a framed serial stream: start bit, 8 data bits LSB first, optional parity bit, then stop bit. It is the transmit-side counterpart of the UART receive path and sits between the system-side byte source and the TX pin. It runs on the same oversampled clock as the receiver, so each bit is held for Prescale clock cycles. It contains a control FSM, a per-bit cycle counter, a bit index counter, a shift register and a parity generator.

---
 rtl/uart_tx_frame_if.sv | 24 ++
 rtl/uart_tx_frame.sv | 133 +++++++++++++
 tb/tb_uart_tx_frame.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// Byte-source / serial-line bundle for the UART frame transmitter.
// The master (byte source) drives the request fields; the slave (transmitter) drives line and status.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [5:0]            Prescale;
    logic                  TX_OUT;
    logic                  Busy;
    logic                  DATA_ACK;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, Busy, DATA_ACK
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, Busy, DATA_ACK
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Every bit lasts Prescale clocks; a new byte can be accepted on the last stop cycle for gapless frames.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_frame_if.slave bus
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  parity_q, parity_d;
    logic [5:0]            prescale_q, prescale_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  ack_q, ack_d;

    logic [5:0] prescale_m1;
    logic       bit_end;
    logic       accept;

    // Prescale of 0 wraps to 63 here, giving 64 cycles per bit.
    assign prescale_m1 = prescale_q - 6'd1;
    assign bit_end     = (cnt_q == prescale_m1);
    assign accept      = bus.DATA_VALID && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        parity_d   = parity_q;
        prescale_d = prescale_q;
        ack_d      = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? 6'd0 : cnt_q + 6'd1;
        end

        case (state_q)
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: begin
            end
        endcase

        // Acceptance overrides the STOP->IDLE exit so back-to-back frames have no idle gap.
        if (accept) begin
            state_d    = START;
            cnt_d      = 6'd0;
            bit_idx_d  = '0;
            shift_d    = bus.P_DATA;
            par_en_d   = bus.PAR_EN;
            parity_d   = (^bus.P_DATA) ^ bus.PAR_TYP;
            prescale_d = bus.Prescale;
            ack_d      = 1'b1;
        end

        // Line value is derived from the next state so TX_OUT can be a plain register.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            parity_q   <= 1'b0;
            prescale_q <= 6'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            parity_q   <= parity_d;
            prescale_q <= prescale_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
        end
    end

    assign bus.TX_OUT   = tx_q;
    assign bus.Busy     = busy_q;
    assign bus.DATA_ACK = ack_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: table of single frames plus back-to-back,
// mid-frame disturbance and mid-frame reset sequences.
module tb_uart_tx_frame;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_frame_if #(.DATA_WIDTH(8)) bus();

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // exp_bits[i] is the i-th bit on the line (index 0 = start bit).
    typedef struct {
        logic [5:0]  prescale;
        logic        par_en;
        logic        par_typ;
        logic [7:0]  data;
        logic [10:0] exp_bits;
        int          exp_len;
        int          disturb_at;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_frame(input logic [5:0] p, input logic pe, input logic pt,
                               input logic [7:0] d, input logic hold);
        @(negedge clk);
        bus.Prescale   = p;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.P_DATA     = d;
        bus.DATA_VALID = 1'b1;
        @(posedge clk);
        #1;
        check("accept_ack", bus.DATA_ACK, 1);
        check("accept_busy", bus.Busy, 1);
        if (!hold) bus.DATA_VALID = 1'b0;
    endtask

    // Starts at frame cycle 0 (just after the accepting edge), ends at cycle len.
    task automatic run_frame(input logic [10:0] exp_bits, input int len, input int p,
                             input int disturb_at,
                             output int bad_bits, output int busy_cnt, output int ack_cnt);
        bad_bits = 0;
        busy_cnt = 0;
        ack_cnt  = 0;
        for (int c = 0; c < len; c++) begin
            if (c == disturb_at) begin
                bus.P_DATA     = ~bus.P_DATA;
                bus.PAR_EN     = ~bus.PAR_EN;
                bus.PAR_TYP    = ~bus.PAR_TYP;
                bus.Prescale   = 6'd16;
                bus.DATA_VALID = 1'b1;
            end
            if (disturb_at >= 0 && c == disturb_at + 1) bus.DATA_VALID = 1'b0;
            if (bus.TX_OUT !== exp_bits[c / p]) bad_bits++;
            if (bus.Busy === 1'b1) busy_cnt++;
            if (bus.DATA_ACK === 1'b1) ack_cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int bad1, busy1, ack1, bad2, busy2, ack2;

        vecs[0] = '{6'd8,  1'b1, 1'b0, 8'hA5, 11'b10101001010, 88,  -1};
        vecs[1] = '{6'd16, 1'b1, 1'b1, 8'h01, 11'b10000000010, 176, -1};
        vecs[2] = '{6'd16, 1'b1, 1'b1, 8'h00, 11'b11000000000, 176, -1};
        vecs[3] = '{6'd16, 1'b0, 1'b0, 8'hFF, 11'b01111111110, 160, -1};
        vecs[4] = '{6'd32, 1'b0, 1'b0, 8'h3C, 11'b01001111000, 320, -1};
        vecs[5] = '{6'd8,  1'b1, 1'b0, 8'hA5, 11'b10101001010, 88,  20};

        bus.P_DATA     = 8'h00;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Prescale   = 6'd8;

        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", bus.TX_OUT, 1);
        check("reset_busy", bus.Busy, 0);
        check("reset_ack", bus.DATA_ACK, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_tx", bus.TX_OUT, 1);
        check("idle_busy", bus.Busy, 0);

        for (int i = 0; i < 6; i++) begin
            start_frame(vecs[i].prescale, vecs[i].par_en, vecs[i].par_typ, vecs[i].data, 1'b0);
            run_frame(vecs[i].exp_bits, vecs[i].exp_len, int'(vecs[i].prescale),
                      vecs[i].disturb_at, bad1, busy1, ack1);
            check($sformatf("v%0d_bad_bit_cycles", i), bad1, 0);
            check($sformatf("v%0d_busy_cycles", i), busy1, vecs[i].exp_len);
            check($sformatf("v%0d_ack_pulses", i), ack1, 1);
            check($sformatf("v%0d_end_busy", i), bus.Busy, 0);
            check($sformatf("v%0d_end_tx", i), bus.TX_OUT, 1);
            $display("vector %0d: data=%02h P=%0d pe=%0b pt=%0b busy=%0d bad=%0d",
                     i, vecs[i].data, vecs[i].prescale, vecs[i].par_en, vecs[i].par_typ, busy1, bad1);
        end

        // Back-to-back: DATA_VALID held, byte swapped on the first ack.
        start_frame(6'd8, 1'b0, 1'b0, 8'h3C, 1'b1);
        bus.P_DATA = 8'hC3;
        run_frame(11'b01001111000, 80, 8, -1, bad1, busy1, ack1);
        check("b2b_second_ack_at_80", bus.DATA_ACK, 1);
        check("b2b_second_start", bus.TX_OUT, 0);
        bus.DATA_VALID = 1'b0;
        run_frame(11'b01110000110, 80, 8, -1, bad2, busy2, ack2);
        check("b2b_bad_bit_cycles", bad1 + bad2, 0);
        check("b2b_busy_cycles", busy1 + busy2, 160);
        check("b2b_ack_pulses", ack1 + ack2, 2);
        check("b2b_end_busy", bus.Busy, 0);
        $display("back-to-back: busy=%0d acks=%0d bad=%0d", busy1 + busy2, ack1 + ack2, bad1 + bad2);

        // Reset during data bit 3 of an 0xA5 frame (that bit is 0 on the line).
        start_frame(6'd8, 1'b1, 1'b0, 8'hA5, 1'b0);
        repeat (35) @(posedge clk);
        #1;
        check("pre_reset_tx_bit3", bus.TX_OUT, 0);
        rst = 1'b1;
        #1;
        check("async_reset_tx", bus.TX_OUT, 1);
        check("async_reset_busy", bus.Busy, 0);
        @(negedge clk);
        bus.DATA_VALID = 1'b1;
        @(posedge clk);
        #1;
        check("reset_wins_ack", bus.DATA_ACK, 0);
        check("reset_wins_busy", bus.Busy, 0);
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        rst = 1'b0;
        start_frame(vecs[1].prescale, vecs[1].par_en, vecs[1].par_typ, vecs[1].data, 1'b0);
        run_frame(vecs[1].exp_bits, vecs[1].exp_len, 16, -1, bad1, busy1, ack1);
        check("post_reset_bad_bit_cycles", bad1, 0);
        check("post_reset_busy_cycles", busy1, 176);
        check("post_reset_ack_pulses", ack1, 1);
        check("post_reset_end_busy", bus.Busy, 0);
        $display("post-reset frame: busy=%0d bad=%0d", busy1, bad1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
